// File: rtl/sudoku_pkg.sv
// Shared constants, requester indices and arbiter types for the sudoku board
// memory subsystem.
package sudoku_pkg;
  localparam int NUM_REQ       = 3;
  localparam int ADDR_W        = 7;
  localparam int DATA_W        = 4;
  localparam int NUM_CELLS     = 81;
  localparam int DISP_MAX_WAIT = 15;
  localparam int WAIT_W        = $clog2(DISP_MAX_WAIT + 1);

  localparam int REQ_LD = 0;
  localparam int REQ_SV = 1;
  localparam int REQ_DP = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;
endpackage

// File: rtl/sudoku_arb_pick.sv
// Combinational winner selection: loader first, then an aged display, then
// round-robin between solver and display.
module sudoku_arb_pick
  import sudoku_pkg::*;
(
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [1:0]         rr_last,
  input  logic               disp_aged,
  output logic [NUM_REQ-1:0] winner
);

  always_comb begin
    winner = '0;
    if (eligible[REQ_LD]) begin
      winner[REQ_LD] = 1'b1;
    end else if (eligible[REQ_DP] && disp_aged) begin
      winner[REQ_DP] = 1'b1;
    end else if (eligible[REQ_SV] && eligible[REQ_DP]) begin
      if (rr_last == 2'(REQ_DP)) winner[REQ_SV] = 1'b1;
      else                       winner[REQ_DP] = 1'b1;
    end else if (eligible[REQ_SV]) begin
      winner[REQ_SV] = 1'b1;
    end else if (eligible[REQ_DP]) begin
      winner[REQ_DP] = 1'b1;
    end
  end

endmodule

// File: rtl/sudoku_mem_arbiter.sv
// Three-master arbiter for the 81-cell board RAM: one access per grant,
// read data returned two cycles after the grant pulse.
module sudoku_mem_arbiter
  import sudoku_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_mode,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      err,
  output logic                      busy,
  output logic                      mem_read_en,
  output logic                      mem_write_en,
  output logic [ADDR_W-1:0]         mem_cell_index,
  output logic [DATA_W-1:0]         mem_data_in,
  input  logic [DATA_W-1:0]         mem_data_out
);

  arb_state_e          state, state_n;
  mem_req_t            reqs [NUM_REQ];
  mem_req_t            sel;
  logic [NUM_REQ-1:0]  eligible, winner, win_q;
  logic                wr_q, err_q, oor, disp_aged;
  logic [1:0]          rr_last;
  logic [WAIT_W-1:0]   disp_wait;

  // Display is read-only, so its write enable is tied off here.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign reqs[i] = {(i == REQ_DP) ? 1'b0 : we[i],
                      addr[i*ADDR_W +: ADDR_W],
                      wdata[i*DATA_W +: DATA_W]};
  end

  assign eligible  = req & (load_mode ? NUM_REQ'(1) : {NUM_REQ{1'b1}});
  assign disp_aged = (disp_wait == WAIT_W'(DISP_MAX_WAIT));

  sudoku_arb_pick u_pick (
    .eligible  (eligible),
    .rr_last   (rr_last),
    .disp_aged (disp_aged),
    .winner    (winner)
  );

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (winner[i]) sel = reqs[i];
  end

  assign oor = (sel.addr >= ADDR_W'(NUM_CELLS));

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (|winner) state_n = ST_ACCESS;
      ST_ACCESS: state_n = wr_q ? ST_IDLE : ST_RESP;
      ST_RESP:   state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt            <= '0;
      rvalid         <= '0;
      rdata          <= '0;
      err            <= 1'b0;
      busy           <= 1'b0;
      mem_read_en    <= 1'b0;
      mem_write_en   <= 1'b0;
      mem_cell_index <= '0;
      mem_data_in    <= '0;
      win_q          <= '0;
      wr_q           <= 1'b0;
      err_q          <= 1'b0;
      rr_last        <= 2'(REQ_DP);
    end else begin
      gnt          <= '0;
      rvalid       <= '0;
      err          <= 1'b0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      busy         <= (state_n != ST_IDLE);
      case (state)
        ST_IDLE: if (|winner) begin
          gnt            <= winner;
          win_q          <= winner;
          err            <= oor;
          err_q          <= oor;
          wr_q           <= sel.we;
          mem_cell_index <= sel.addr;
          mem_data_in    <= sel.wdata;
          mem_write_en   <= sel.we & ~oor;
          mem_read_en    <= ~sel.we & ~oor;
        end
        ST_ACCESS: begin
          if (win_q[REQ_SV])      rr_last <= 2'(REQ_SV);
          else if (win_q[REQ_DP]) rr_last <= 2'(REQ_DP);
        end
        ST_RESP: begin
          rvalid <= win_q;
          rdata  <= err_q ? '0 : mem_data_out;
        end
        default: ;
      endcase
    end
  end

  // Aging only runs outside load mode so a long load does not promote display.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_wait <= '0;
    end else if (!load_mode) begin
      if (gnt[REQ_DP] || !req[REQ_DP]) disp_wait <= '0;
      else if (!disp_aged)             disp_wait <= disp_wait + 1'b1;
    end
  end

endmodule
